// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the bit-serial compare sequencer: state encoding,
// the default operand width and a small one-hot check helper.
package serial_cmp_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SHIFT  = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic logic is_onehot3(input logic l, input logic e, input logic g);
    return (l & ~e & ~g) | (~l & e & ~g) | (~l & ~e & g);
  endfunction

endpackage

// File: rtl/operand_piso.sv
// Parallel-in / serial-out operand register; emits bit 0 first and shifts
// right, so the operand leaves LSB-first.
module operand_piso #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] par_in,
  output logic             ser_out
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = par_in;
    end else if (shift) begin
      sr_d = {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign ser_out = sr_q[0];

endmodule

// File: rtl/serial_compare_ctrl.sv
// Sequencer for an external bit-serial unsigned comparator: takes an operand
// pair, streams it LSB-first, then captures and hands back L/E/G.
module serial_compare_ctrl
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  output logic             cmp_clr,
  output logic             cmp_en,
  output logic             ser_a,
  output logic             ser_b,
  input  logic             cmp_L,
  input  logic             cmp_E,
  input  logic             cmp_G,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_L,
  output logic             out_E,
  output logic             out_G,
  output logic             out_err,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_l_q, out_l_d;
  logic             out_e_q, out_e_d;
  logic             out_g_q, out_g_d;
  logic             out_err_q, out_err_d;
  logic             load, shift;
  logic [WIDTH-1:0] load_a, load_b;
  logic             bit_a, bit_b;

  // Flipping the MSB maps two's-complement order onto unsigned order.
  always_comb begin
    load_a            = in_a;
    load_b            = in_b;
    load_a[WIDTH-1]   = in_a[WIDTH-1] ^ in_signed;
    load_b[WIDTH-1]   = in_b[WIDTH-1] ^ in_signed;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_l_d   = out_l_q;
    out_e_d   = out_e_q;
    out_g_d   = out_g_q;
    out_err_d = out_err_q;
    load      = 1'b0;
    shift     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        shift = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        out_l_d   = cmp_L;
        out_e_d   = cmp_E;
        out_g_d   = cmp_G;
        out_err_d = ~is_onehot3(cmp_L, cmp_E, cmp_G);
        state_d   = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      out_l_q   <= 1'b0;
      out_e_q   <= 1'b0;
      out_g_q   <= 1'b0;
      out_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_l_q   <= out_l_d;
      out_e_q   <= out_e_d;
      out_g_q   <= out_g_d;
      out_err_q <= out_err_d;
    end
  end

  operand_piso #(.WIDTH(WIDTH)) u_piso_a (
    .clk(clk), .rst(rst), .load(load), .shift(shift), .par_in(load_a), .ser_out(bit_a)
  );

  operand_piso #(.WIDTH(WIDTH)) u_piso_b (
    .clk(clk), .rst(rst), .load(load), .shift(shift), .par_in(load_b), .ser_out(bit_b)
  );

  // Gating cmp_en with rst keeps it disjoint from the reset-forced clear.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign cmp_clr   = ~rst | (state_q == CLEAR);
  assign cmp_en    = rst & (state_q == SHIFT);
  assign ser_a     = cmp_en & bit_a;
  assign ser_b     = cmp_en & bit_b;
  assign out_L     = out_l_q;
  assign out_E     = out_e_q;
  assign out_G     = out_g_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl, paired with a behavioural
// LSB-first bit-serial unsigned comparator.
module tb_serial_compare_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_signed;
  logic        cmp_clr;
  logic        cmp_en;
  logic        ser_a;
  logic        ser_b;
  logic        cmp_L, cmp_E, cmp_G;
  logic        out_valid;
  logic        out_ready;
  logic        out_L, out_E, out_G;
  logic        out_err;
  logic        busy;

  int testsRun    = 0;
  int testsFailed = 0;
  int overlapSeen = 0;

  serial_compare_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .cmp_clr(cmp_clr), .cmp_en(cmp_en), .ser_a(ser_a), .ser_b(ser_b),
    .cmp_L(cmp_L), .cmp_E(cmp_E), .cmp_G(cmp_G),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_L(out_L), .out_E(out_E), .out_G(out_G),
    .out_err(out_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Later bits outrank earlier ones, so any differing bit overwrites the verdict.
  always_ff @(posedge clk) begin
    if (cmp_clr) begin
      cmp_L <= 1'b0;
      cmp_E <= 1'b1;
      cmp_G <= 1'b0;
    end else if (cmp_en && (ser_a != ser_b)) begin
      cmp_L <= ~ser_a;
      cmp_E <= 1'b0;
      cmp_G <= ser_a;
    end
  end

  always @(negedge clk) begin
    if (cmp_clr && cmp_en) overlapSeen++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers one operand pair while idle; returns just after the accepting edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    in_a      = a;
    in_b      = b;
    in_signed = sgn;
    in_valid  = 1'b1;
    step(1);
    in_valid  = 1'b0;
  endtask

  task automatic waitValid(output int edges);
    edges = 0;
    while (!out_valid && edges < 100) begin
      step(1);
      edges++;
    end
  endtask

  task automatic runCompare(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic sgn, input logic [2:0] expLeg);
    int edges;
    applyStimulus(a, b, sgn);
    waitValid(edges);
    checkOutput({tag, "_latency"}, 32'(edges), 32'd34);
    checkOutput({tag, "_LEG"}, {29'd0, out_L, out_E, out_G}, {29'd0, expLeg});
    checkOutput({tag, "_err"}, {31'd0, out_err}, 32'd0);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    checkOutput({tag, "_released"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    int acceptCycles[$];
    int cyc;
    logic acc;

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    step(2);

    checkOutput("reset_ready_valid_busy", {29'd0, in_ready, out_valid, busy}, 32'b100);
    checkOutput("reset_LEG_err", {28'd0, out_L, out_E, out_G, out_err}, 32'd0);
    checkOutput("reset_clr_en_ser", {28'd0, cmp_clr, cmp_en, ser_a, ser_b}, 32'b1000);
    rst = 1'b1;
    #1;
    checkOutput("post_reset_clr", {31'd0, cmp_clr}, 32'd0);

    runCompare("uns_big", 32'hFFFF_FFFF, 32'd123, 1'b0, 3'b001);
    checkOutput("result_kept_in_idle", {29'd0, out_L, out_E, out_G}, 32'b001);
    runCompare("sgn_neg1", 32'hFFFF_FFFF, 32'd123, 1'b1, 3'b100);
    runCompare("uns_equal", 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b0, 3'b010);
    runCompare("sgn_minmax", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b100);
    runCompare("uns_minmax", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b001);

    // Hold DONE with out_ready low while offering operands that must be ignored.
    begin
      int edges;
      applyStimulus(32'd7, 32'd7, 1'b0);
      waitValid(edges);
      checkOutput("hold_latency", 32'(edges), 32'd34);
      for (int i = 0; i < 10; i++) begin
        in_a     = 32'd1;
        in_b     = 32'd2;
        in_valid = i[0];
        step(1);
        checkOutput("hold_state", {26'd0, out_valid, in_ready, busy, out_L, out_E, out_G}, 32'b101010);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
      step(2);
      checkOutput("hold_no_latch", {30'd0, in_ready, busy}, 32'b10);
    end

    // Reset mid-shift: after the accept edge, the CLEAR edge plus ten SHIFT edges.
    applyStimulus(32'hFFFF_0000, 32'h0000_FFFF, 1'b0);
    step(11);
    checkOutput("pre_reset_shifting", {30'd0, cmp_en, busy}, 32'b11);
    rst = 1'b0;
    #1;
    checkOutput("reset_mid_clr_en", {30'd0, cmp_clr, cmp_en}, 32'b10);
    step(1);
    checkOutput("reset_mid_state", {29'd0, in_ready, out_valid, busy}, 32'b100);
    checkOutput("reset_mid_clr", {31'd0, cmp_clr}, 32'd1);
    rst = 1'b1;
    #1;
    runCompare("after_reset", 32'd5, 32'd9, 1'b0, 3'b100);

    // Back-to-back accepts with both handshakes held high.
    out_ready   = 1'b1;
    in_a        = 32'd3;
    in_b        = 32'd4;
    in_signed   = 1'b0;
    in_valid    = 1'b1;
    overlapSeen = 0;
    cyc         = 0;
    while (acceptCycles.size() < 3 && cyc < 200) begin
      acc = in_valid & in_ready;
      step(1);
      cyc++;
      if (acc) acceptCycles.push_back(cyc);
    end
    in_valid  = 1'b0;
    checkOutput("b2b_accepts", 32'(acceptCycles.size()), 32'd3);
    if (acceptCycles.size() == 3) begin
      checkOutput("b2b_period1", 32'(acceptCycles[1] - acceptCycles[0]), 32'd36);
      checkOutput("b2b_period2", 32'(acceptCycles[2] - acceptCycles[1]), 32'd36);
    end
    step(40);
    out_ready = 1'b0;
    checkOutput("b2b_last_result", {29'd0, out_L, out_E, out_G}, 32'b100);
    checkOutput("clr_en_overlap", 32'(overlapSeen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
